// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: AES-CTR datapath behind the MMIO front-end.
//
// Buffers input blocks together with the counter value captured on each input
// handshake, sends one counter at a time to an external AES-256 encrypt core,
// XORs the returned keystream with the matching input block and presents the
// result on the output stream. Blocks leave in the order they arrived.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset (hard or soft reset)
//   aes_key           256-bit key, forwarded unchanged on core_key
//   aes_ctr           counter value, captured with each accepted input block
//   aes_in_*          input block stream (valid/ready)
//   aes_out_*         output block stream (valid/ready), block = input ^ keystream
//   aes_fifo_empty    nothing stored, in flight or waiting at the output
//   core_req_*        encrypt request to the core (valid/ready), block = counter
//   core_resp_*       keystream from the core; valid is a single-cycle pulse
module aes_ctr_stream #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] aes_key,
    input  logic [127:0] aes_ctr,
    output logic         aes_in_ready,
    input  logic         aes_in_valid,
    input  logic [127:0] aes_in_block,
    input  logic         aes_out_ready,
    output logic         aes_out_valid,
    output logic [127:0] aes_out_block,
    output logic         aes_fifo_empty,
    output logic [255:0] core_key,
    input  logic         core_req_ready,
    output logic         core_req_valid,
    output logic [127:0] core_req_block,
    input  logic         core_resp_valid,
    input  logic [127:0] core_resp_block
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StOut
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [127:0]       out_reg;

    // Each entry is {block, counter}; storage needs no reset because the
    // pointers and count decide what is valid.
    logic [255:0]       mem [DEPTH];
    logic [127:0]       head_block;
    logic [127:0]       head_ctr;

    logic push;
    logic pop;

    assign head_block = mem[rd_ptr][255:128];
    assign head_ctr   = mem[rd_ptr][127:0];

    // Ready depends on the registered count only, never on a same-cycle pop.
    assign aes_in_ready = (count != FULL_COUNT);
    assign push         = aes_in_valid & aes_in_ready;
    // The head entry is retired as soon as its keystream arrives; the result
    // then lives in out_reg, which frees a FIFO slot during back-pressure.
    assign pop          = (state == StWait) & core_resp_valid;

    assign core_key       = aes_key;
    assign core_req_valid = (state == StIssue);
    assign core_req_block = head_ctr;
    assign aes_out_valid  = (state == StOut);
    assign aes_out_block  = out_reg;
    assign aes_fifo_empty = (count == '0) & (state == StIdle);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {aes_in_block, aes_ctr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state   <= StIdle;
            out_reg <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            unique case (state)
                StIdle: begin
                    if (count != '0) begin
                        state <= StIssue;
                    end
                end
                StIssue: begin
                    if (core_req_ready) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (core_resp_valid) begin
                        out_reg <= head_block ^ core_resp_block;
                        state   <= StOut;
                    end
                end
                StOut: begin
                    // count already reflects the pop done in StWait.
                    if (aes_out_ready) begin
                        state <= (count != '0) ? StIssue : StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Testbench for aes_ctr_stream: stub encrypt core, scoreboard and directed plus
// randomized stimulus. Expected results are computed from the block/counter
// pairs offered at the input and a keystream function of the counter.
module tb_aes_ctr_stream;

    localparam int unsigned DEPTH = 4;

    localparam logic [255:0] KAT_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KAT_CTR = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_KS  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] aes_key = '0;
    logic [127:0] aes_ctr = '0;
    logic         aes_in_ready;
    logic         aes_in_valid = 1'b0;
    logic [127:0] aes_in_block = '0;
    logic         aes_out_ready = 1'b0;
    logic         aes_out_valid;
    logic [127:0] aes_out_block;
    logic         aes_fifo_empty;
    logic [255:0] core_key;
    logic         core_req_ready = 1'b0;
    logic         core_req_valid;
    logic [127:0] core_req_block;
    logic         core_resp_valid = 1'b0;
    logic [127:0] core_resp_block = '0;

    aes_ctr_stream #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .aes_key         (aes_key),
        .aes_ctr         (aes_ctr),
        .aes_in_ready    (aes_in_ready),
        .aes_in_valid    (aes_in_valid),
        .aes_in_block    (aes_in_block),
        .aes_out_ready   (aes_out_ready),
        .aes_out_valid   (aes_out_valid),
        .aes_out_block   (aes_out_block),
        .aes_fifo_empty  (aes_fifo_empty),
        .core_key        (core_key),
        .core_req_ready  (core_req_ready),
        .core_req_valid  (core_req_valid),
        .core_req_block  (core_req_block),
        .core_resp_valid (core_resp_valid),
        .core_resp_block (core_resp_block)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_out[$];
    logic [127:0] exp_req[$];
    logic [127:0] ctr_val = '0;

    bit hold_core = 1'b0;
    bit hold_out  = 1'b0;
    int lat_sel   = 3;      // 0: random latency 1..5, else fixed latency
    bit req_seen  = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Keystream the stub core produces: the real AES-256 result for the known
    // test vector, counter+1 for everything else.
    function automatic logic [127:0] keystream(input logic [255:0] key, input logic [127:0] ctr);
        if (key == KAT_KEY && ctr == KAT_CTR) return KAT_KS;
        return ctr + 128'd1;
    endfunction

    // Stub encrypt core: one request at a time, response after a latency.
    int           lat_cnt = 0;
    bit           busy = 1'b0;
    logic [127:0] ks = '0;

    always @(negedge clk) begin
        core_resp_valid = 1'b0;
        if (busy) begin
            lat_cnt--;
            if (lat_cnt <= 0) begin
                core_resp_valid = 1'b1;
                core_resp_block = ks;
                busy = 1'b0;
            end
        end
        core_req_ready = !hold_core && !busy && ($urandom_range(0, 3) != 0);
        #1;
        if (!rst && core_req_valid && core_req_ready) begin
            if (exp_req.size() == 0) check("core_req_unexpected", 1, 0);
            else check("core_req_block", core_req_block, exp_req.pop_front());
            check("core_key", core_key, aes_key);
            ks = keystream(core_key, core_req_block);
            busy = 1'b1;
            lat_cnt = (lat_sel == 0) ? int'($urandom_range(1, 5)) : lat_sel;
            req_seen = 1'b1;
        end
    end

    // Output monitor: random consumer ready, hold stability and scoreboard.
    bit           stall = 1'b0;
    logic [127:0] stall_blk = '0;

    always @(negedge clk) begin
        aes_out_ready = !hold_out && ($urandom_range(0, 2) != 0);
        #1;
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("out_hold_valid", aes_out_valid, 1);
                check("out_hold_block", aes_out_block, stall_blk);
            end
            stall = 1'b0;
            if (aes_out_valid && aes_out_ready) begin
                if (exp_out.size() == 0) check("out_unexpected", 1, 0);
                else check("out_block", aes_out_block, exp_out.pop_front());
            end else if (aes_out_valid) begin
                stall = 1'b1;
                stall_blk = aes_out_block;
            end
        end
    end

    // Offer a block starting in the current low clock phase; record the
    // expectation on acceptance, then advance the front-end counter.
    task automatic offer(input logic [127:0] blk);
        int n = 0;
        aes_in_valid = 1'b1;
        aes_in_block = blk;
        aes_ctr = ctr_val;
        #1;
        while (!aes_in_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("in_accepted", aes_in_ready, 1);
        if (aes_in_ready) begin
            exp_out.push_back(blk ^ keystream(aes_key, ctr_val));
            exp_req.push_back(ctr_val);
            @(posedge clk);
            #1;
            ctr_val = ctr_val + 128'd1;
        end
        aes_in_valid = 1'b0;
        aes_ctr = ctr_val;
    endtask

    task automatic push(input logic [127:0] blk);
        @(negedge clk);
        offer(blk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_out.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drained_out", exp_out.size(), 0);
        check("drained_req", exp_req.size(), 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        aes_key = rand128() ^ {rand128(), 128'h0};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready", aes_in_ready, 1);
        check("rst_out_valid", aes_out_valid, 0);
        check("rst_req_valid", core_req_valid, 0);
        check("rst_empty", aes_fifo_empty, 1);
        check("rst_out_block", aes_out_block, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single block, fixed 3-cycle core latency.
        lat_sel = 3;
        ctr_val = 128'h5;
        push({8{16'h00FF}});
        check("single_empty_busy", aes_fifo_empty, 0);
        wait_drain();
        check("single_empty_done", aes_fifo_empty, 1);

        // Back-to-back blocks with consecutive counters 7..10.
        ctr_val = 128'h7;
        for (int i = 0; i < 4; i++) push(rand128());
        wait_drain();

        // Full FIFO under output back-pressure: five accepted, sixth stalls.
        hold_out = 1'b1;
        for (int i = 0; i < 5; i++) push(rand128());
        check("full_in_ready", aes_in_ready, 0);
        begin
            int ready_cycles = 0;
            @(negedge clk);
            aes_in_valid = 1'b1;
            aes_in_block = rand128();
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                #1;
                if (aes_in_ready) ready_cycles++;
            end
            aes_in_valid = 1'b0;
            check("full_stays_blocked", ready_cycles, 0);
        end
        hold_out = 1'b0;
        wait_drain();

        // Simultaneous push and pop with three entries stored.
        hold_core = 1'b1;
        hold_out = 1'b1;
        for (int i = 0; i < 3; i++) push(rand128());
        hold_core = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            #2;
            if (core_resp_valid) found = 1'b1;
        end
        check("pp_resp_seen", found, 1);
        offer(rand128());
        @(negedge clk);
        #2;
        check("pp_in_ready", aes_in_ready, 1);
        push(rand128());
        @(negedge clk);
        #2;
        check("pp_then_full", aes_in_ready, 0);
        hold_out = 1'b0;
        wait_drain();

        // Known AES-256 vector through the XOR path.
        begin
            logic [255:0] saved_key;
            saved_key = aes_key;
            aes_key = KAT_KEY;
            ctr_val = KAT_CTR;
            push(128'h0);
            wait_drain();
            aes_key = saved_key;
        end

        // Reset while a request is outstanding with more blocks queued.
        hold_core = 1'b1;
        lat_sel = 8;
        for (int i = 0; i < 3; i++) push(rand128());
        req_seen = 1'b0;
        hold_core = 1'b0;
        for (int i = 0; i < 80 && !req_seen; i++) begin
            @(negedge clk);
            #2;
        end
        check("rst_req_seen", req_seen, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", aes_out_valid, 0);
        check("midrst_in_ready", aes_in_ready, 1);
        check("midrst_empty", aes_fifo_empty, 1);
        exp_out.delete();
        exp_req.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #2;
            check("late_resp_no_out", aes_out_valid, 0);
            check("late_resp_empty", aes_fifo_empty, 1);
        end

        // Randomized traffic: random data, gaps, latency and consumer stalls.
        lat_sel = 0;
        ctr_val = rand128();
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 9) == 0) ctr_val = rand128();
            push(rand128());
        end
        wait_drain();
        check("final_empty", aes_fifo_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_ctr_stream.md
Name: aes_ctr_stream

Overview:
- Downstream neighbour of the MMIO accelerator front-end.
- Consumes 128-bit input blocks plus the current counter/key, and drives an AES-256 block-encrypt core with the captured counter.
- XORs the returned keystream with the buffered input block and presents the result as the output block stream.
- Provides the "pipeline empty" status that the front-end folds into its busy bit.

Parameters:
DEPTH, 4, input-entry FIFO depth; power of two, ≥2.

Ports:
clk  in  1  clock
rst  in  1  reset; covers both hard reset and front-end soft reset
aes_key  in  256  key, passed through to core
aes_ctr  in  128  current counter value; sampled on input handshake
aes_in_ready  out  1  input FIFO can accept a block
aes_in_valid  in  1  input block valid
aes_in_block  in  128  input (plaintext/ciphertext) block
aes_out_ready  in  1  consumer accepts output block
aes_out_valid  out  1  output block valid
aes_out_block  out  128  input XOR keystream
aes_fifo_empty  out  1  no stored, in-flight or pending-output data
core_key  out  256  key to encrypt core (= aes_key)
core_req_ready  in  1  core accepts request
core_req_valid  out  1  encrypt request
core_req_block  out  128  counter block to encrypt
core_resp_valid  in  1  one-cycle pulse, keystream valid
core_resp_block  in  128  keystream

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. All state is reset by rst: FIFO pointers and count = 0, state = IDLE, out register = 0. Outputs after reset: aes_in_ready=1, aes_out_valid=0, core_req_valid=0, aes_fifo_empty=1, aes_out_block=0.
- Input FIFO:
  - DEPTH entries of {block[127:0], ctr[127:0]}; count width clog2(DEPTH)+1.
  - aes_in_ready = (count != DEPTH). It is derived from count only, never combinationally from a same-cycle pop.
  - Push on aes_in_valid & aes_in_ready: stores aes_in_block and the aes_ctr value present in that cycle. This is the pre-increment value; the front-end increments on the same handshake.
  - Pop occurs only in WAIT on core_resp_valid.
  - Simultaneous push and pop: count unchanged, both performed. Pointers wrap modulo DEPTH.
- FSM (one outstanding core request; strictly in-order):
  - IDLE: if count != 0 → ISSUE.
  - ISSUE: core_req_valid=1, core_req_block = head.ctr. On core_req_ready → WAIT.
  - WAIT: core_req_valid=0. On core_resp_valid: out_reg <= head.block ^ core_resp_block, pop head, → OUT.
  - OUT: aes_out_valid=1, aes_out_block=out_reg, held stable until aes_out_ready. On aes_out_ready: → ISSUE if the post-pop count != 0, else → IDLE.
- core_resp_valid outside WAIT is ignored; no state change.
- core_key = aes_key combinationally. Key stability during operation is the front-end's responsibility.
- aes_fifo_empty = (count == 0) & (state == IDLE). It is therefore 0 during ISSUE/WAIT/OUT.
- Latency, empty pipeline, zero-wait consumer: input handshake at cycle T → ISSUE at T+1 → core request handshake ≥T+2 → output valid the cycle after core_resp_valid.
- Back-pressure: while in OUT, the FIFO keeps accepting input until full; no data is lost or reordered.
- rst mid-operation: buffered and in-flight data are discarded. The core shares rst, so no stale response is expected. aes_out_valid drops immediately (asynchronous).

Test Plan:
- Single block, stub core (keystream = ctr+1, 3-cycle latency): in=128'h00FF..00FF, ctr=128'h5 → core_req_block=5, aes_out_block=in^128'h6. aes_fifo_empty: 1→0 on push, 1 after out handshake.
- Counter capture: ctr increments 7,8,9,10 on each handshake of 4 back-to-back blocks → core_req_block sequence 7,8,9,10; outputs in order.
- Full/back-pressure: DEPTH=4, aes_out_ready=0, push 6 blocks → aes_in_ready=0 after the 5th accepted (4 in FIFO + 1 in OUT). Release ready → 5 outputs in order, no loss.
- Simultaneous push/pop at count==DEPTH−1 → count stays DEPTH−1, aes_in_ready remains 1.
- Real AES-256 core, key=000102…1f, in=0, ctr=00112233445566778899aabbccddeeff → aes_out_block=8ea2b7ca516745bfeafc49904b496089.
- rst asserted during WAIT with 2 queued blocks → next cycle aes_out_valid=0, aes_in_ready=1, aes_fifo_empty=1. A late core_resp_valid pulse produces no output.
